// File: rtl/flash_op_sequencer.sv
// Expands one macro flash operation (erase, program, read page, read status) into the ordered
// QSPI command transactions: write-enable preamble, the operation itself and RDSR busy polling.
module flash_op_sequencer #(
  parameter int unsigned POLL_GAP      = 64,
  parameter int unsigned TIMEOUT_POLLS = 1_000_000,
  parameter int unsigned PAGE_BYTES    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] op_addr,
  output logic        op_ready,
  output logic        op_done,
  output logic        op_error,
  output logic [7:0]  sr_out,
  output logic        busy,
  output logic        eng_valid,
  input  logic        eng_ready,
  output logic [7:0]  eng_opcode,
  output logic [23:0] eng_addr,
  output logic        eng_addr_en,
  output logic [8:0]  eng_len,
  input  logic        eng_done,
  input  logic [7:0]  eng_sr
);

  localparam int unsigned     GapW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GapW-1:0] GapReload = GapW'(POLL_GAP - 1);
  localparam logic [23:0]     PollLimit = 24'(TIMEOUT_POLLS);
  localparam logic [8:0]      PageLen   = 9'(PAGE_BYTES);

  localparam logic [3:0] OpErase  = 4'hA;
  localparam logic [3:0] OpProg   = 4'hC;
  localparam logic [3:0] OpRead   = 4'hD;
  localparam logic [3:0] OpStatus = 4'hE;

  localparam logic [7:0] CmdWren  = 8'h06;
  localparam logic [7:0] CmdRdsr  = 8'h05;
  localparam logic [7:0] CmdErase = 8'h20;
  localparam logic [7:0] CmdProg  = 8'h02;
  localparam logic [7:0] CmdRead  = 8'h03;

  // StReject adds one cycle so an illegal code completes two cycles after accept.
  typedef enum logic [3:0] {
    StIdle, StWrenReq, StWrenWait, StOpReq, StOpWait,
    StGap, StRdsrReq, StRdsrWait, StReject, StFinish
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      code_q, code_d;
  logic [23:0]     addr_q, addr_d;
  logic            err_q, err_d;
  logic [7:0]      sr_q, sr_d;
  logic [23:0]     poll_cnt_q, poll_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            eng_valid_q, eng_valid_d;
  logic [7:0]      eng_opcode_q, eng_opcode_d;
  logic [23:0]     eng_addr_q, eng_addr_d;
  logic            eng_addr_en_q, eng_addr_en_d;
  logic [8:0]      eng_len_q, eng_len_d;

  logic            req_active;
  logic [7:0]      req_opcode;
  logic            req_addr_en;
  logic [8:0]      req_len;
  state_e          req_next;
  logic [23:0]     poll_inc;

  logic unused_addr_hi;
  assign unused_addr_hi = ^op_addr[31:24];

  // Transaction descriptor for whichever *_REQ state is current.
  always_comb begin
    req_active  = 1'b0;
    req_opcode  = CmdRdsr;
    req_addr_en = 1'b0;
    req_len     = 9'd0;
    req_next    = StRdsrWait;
    unique case (state_q)
      StWrenReq: begin
        req_active = 1'b1;
        req_opcode = CmdWren;
        req_next   = StWrenWait;
      end
      StOpReq: begin
        req_active  = 1'b1;
        req_addr_en = 1'b1;
        req_next    = StOpWait;
        unique case (code_q)
          OpErase: req_opcode = CmdErase;
          OpProg: begin
            req_opcode = CmdProg;
            req_len    = PageLen;
          end
          default: begin
            req_opcode = CmdRead;
            req_len    = PageLen;
          end
        endcase
      end
      StRdsrReq: begin
        req_active = 1'b1;
        req_len    = 9'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    addr_d        = addr_q;
    err_d         = err_q;
    sr_d          = sr_q;
    poll_cnt_d    = poll_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    eng_valid_d   = eng_valid_q;
    eng_opcode_d  = eng_opcode_q;
    eng_addr_d    = eng_addr_q;
    eng_addr_en_d = eng_addr_en_q;
    eng_len_d     = eng_len_q;
    poll_inc      = poll_cnt_q + 24'd1;

    // Fields load once when the request is raised and hold until the engine takes them.
    if (req_active) begin
      if (!eng_valid_q) begin
        eng_valid_d   = 1'b1;
        eng_opcode_d  = req_opcode;
        eng_addr_en_d = req_addr_en;
        eng_len_d     = req_len;
        if (req_addr_en) begin
          eng_addr_d = addr_q;
        end
      end else if (eng_ready) begin
        eng_valid_d = 1'b0;
        state_d     = req_next;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          code_d     = op_code;
          addr_d     = op_addr[23:0];
          err_d      = 1'b0;
          poll_cnt_d = '0;
          case (op_code)
            OpErase, OpProg: state_d = StWrenReq;
            OpRead:          state_d = StOpReq;
            OpStatus:        state_d = StRdsrReq;
            default: begin
              err_d   = 1'b1;
              state_d = StReject;
            end
          endcase
        end
      end
      StWrenWait: begin
        if (eng_done) begin
          state_d = StOpReq;
        end
      end
      StOpWait: begin
        if (eng_done) begin
          if (code_q == OpRead) begin
            state_d = StFinish;
          end else begin
            state_d   = StGap;
            gap_cnt_d = GapReload;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StRdsrReq;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      StRdsrWait: begin
        if (eng_done) begin
          sr_d       = eng_sr;
          poll_cnt_d = poll_inc;
          if (code_q == OpStatus || !eng_sr[0]) begin
            state_d = StFinish;
          end else if (poll_inc >= PollLimit) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            state_d   = StGap;
            gap_cnt_d = GapReload;
          end
        end
      end
      StReject: state_d = StFinish;
      StFinish: state_d = StIdle;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      code_q        <= '0;
      addr_q        <= '0;
      err_q         <= 1'b0;
      sr_q          <= '0;
      poll_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      eng_valid_q   <= 1'b0;
      eng_opcode_q  <= '0;
      eng_addr_q    <= '0;
      eng_addr_en_q <= 1'b0;
      eng_len_q     <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      addr_q        <= addr_d;
      err_q         <= err_d;
      sr_q          <= sr_d;
      poll_cnt_q    <= poll_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      eng_valid_q   <= eng_valid_d;
      eng_opcode_q  <= eng_opcode_d;
      eng_addr_q    <= eng_addr_d;
      eng_addr_en_q <= eng_addr_en_d;
      eng_len_q     <= eng_len_d;
    end
  end

  assign op_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign op_done     = (state_q == StFinish);
  assign op_error    = (state_q == StFinish) && err_q;
  assign sr_out      = sr_q;
  assign eng_valid   = eng_valid_q;
  assign eng_opcode  = eng_opcode_q;
  assign eng_addr    = eng_addr_q;
  assign eng_addr_en = eng_addr_en_q;
  assign eng_len     = eng_len_q;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Bench for flash_op_sequencer: engine responder, table vectors, reset-in-GAP sequence and
// randomized operations scored against a transaction-list model.
module tb_flash_op_sequencer;

  localparam int PollGap      = 8;
  localparam int TimeoutPolls = 4;
  localparam int PageBytes    = 256;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] addr;
    logic        addr_en;
    logic [8:0]  len;
  } txn_t;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] addr;
    int          n_wip;
    logic [7:0]  fin;
    int          rdly;
    int          exp_n;
    logic        exp_err;
    logic [7:0]  exp_sr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  op_code = 4'h0;
  logic [31:0] op_addr = 32'h0;
  logic        op_ready, op_done, op_error, busy;
  logic [7:0]  sr_out;
  logic        eng_valid, eng_addr_en;
  logic        eng_ready = 1'b0;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_sr = 8'h00;
  logic [7:0]  eng_opcode;
  logic [23:0] eng_addr;
  logic [8:0]  eng_len;

  flash_op_sequencer #(
    .POLL_GAP      (PollGap),
    .TIMEOUT_POLLS (TimeoutPolls),
    .PAGE_BYTES    (PageBytes)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_addr     (op_addr),
    .op_ready    (op_ready),
    .op_done     (op_done),
    .op_error    (op_error),
    .sr_out      (sr_out),
    .busy        (busy),
    .eng_valid   (eng_valid),
    .eng_ready   (eng_ready),
    .eng_opcode  (eng_opcode),
    .eng_addr    (eng_addr),
    .eng_addr_en (eng_addr_en),
    .eng_len     (eng_len),
    .eng_done    (eng_done),
    .eng_sr      (eng_sr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // Engine / monitor state
  int         ph = 0;
  int         wait_cnt = 0;
  int         lat = 0;
  int         ready_dly = 0;
  int         vcyc_now = 0;
  txn_t       snap;
  txn_t       log_q[$];
  int         vcyc_q[$];
  int         dcyc_q[$];
  logic [7:0] resp_q[$];
  bit         unstable = 1'b0;
  bit         stray = 1'b0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       done_err = 1'b0;
  logic [7:0] done_sr = 8'h00;

  // Model state
  txn_t       exp_q[$];
  logic       m_err = 1'b0;
  logic [7:0] m_sr = 8'h00;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic txn_t mk(input logic [7:0] op, input logic [23:0] a, input logic en,
                              input logic [8:0] len);
    txn_t t;
    t.opcode  = op;
    t.addr    = en ? a : 24'h0;
    t.addr_en = en;
    t.len     = len;
    return t;
  endfunction

  function automatic txn_t norm(input txn_t t);
    txn_t r;
    r = t;
    if (!r.addr_en) r.addr = 24'h0;
    return r;
  endfunction

  function automatic logic [7:0] resp_at(input int i);
    if (i < resp_q.size()) return resp_q[i];
    return 8'h00;
  endfunction

  // Expected transaction list, error and status byte for one operation.
  function automatic void model(input logic [3:0] code, input logic [23:0] a);
    exp_q.delete();
    m_err = 1'b0;
    case (code)
      4'hA, 4'hC: begin
        exp_q.push_back(mk(8'h06, 24'h0, 1'b0, 9'd0));
        if (code == 4'hA) exp_q.push_back(mk(8'h20, a, 1'b1, 9'd0));
        else              exp_q.push_back(mk(8'h02, a, 1'b1, 9'(PageBytes)));
        for (int i = 0; i < TimeoutPolls; i++) begin
          exp_q.push_back(mk(8'h05, 24'h0, 1'b0, 9'd1));
          m_sr = resp_at(i);
          if (!m_sr[0]) break;
          if (i == TimeoutPolls - 1) m_err = 1'b1;
        end
      end
      4'hD: exp_q.push_back(mk(8'h03, a, 1'b1, 9'(PageBytes)));
      4'hE: begin
        exp_q.push_back(mk(8'h05, 24'h0, 1'b0, 9'd1));
        m_sr = resp_at(0);
      end
      default: m_err = 1'b1;
    endcase
  endfunction

  // Engine responder and completion monitor, all activity on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (op_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = op_error;
        done_sr  = sr_out;
      end
      if (op_error && !op_done) stray = 1'b1;
      if (rst) begin
        ph = 0;
        eng_ready = 1'b0;
      end else begin
        case (ph)
          0: if (eng_valid) begin
            snap = {eng_opcode, eng_addr, eng_addr_en, eng_len};
            vcyc_now = cyc;
            wait_cnt = 0;
            ph = 1;
            if (ready_dly == 0) begin
              eng_ready = 1'b1;
              ph = 2;
            end
          end
          1: begin
            if (!eng_valid || snap != {eng_opcode, eng_addr, eng_addr_en, eng_len})
              unstable = 1'b1;
            wait_cnt++;
            if (wait_cnt >= ready_dly) begin
              eng_ready = 1'b1;
              ph = 2;
            end
          end
          2: begin
            eng_ready = 1'b0;
            if (eng_valid) unstable = 1'b1;
            log_q.push_back(snap);
            vcyc_q.push_back(vcyc_now);
            lat = int'($urandom_range(1, 3));
            ph = 3;
          end
          default: begin
            lat--;
            if (lat <= 0) begin
              eng_done = 1'b1;
              if (snap.opcode == 8'h05) eng_sr = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
              else eng_sr = 8'hA5;
              dcyc_q.push_back(cyc);
              ph = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input int rdly,
                        output int act_n, output logic act_err, output logic [7:0] act_sr);
    int t;
    int d0;
    int acc;
    int nmin;
    model(code, a[23:0]);
    log_q.delete();
    vcyc_q.delete();
    dcyc_q.delete();
    unstable = 1'b0;
    ready_dly = rdly;
    t = 0;
    while (!op_ready && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check("idle_before_op", 64'(op_ready), 64'(1));
    d0 = done_cnt;
    op_valid = 1'b1;
    op_code = code;
    op_addr = a;
    acc = cyc;
    @(negedge clk); #1;
    op_valid = 1'b0;
    op_code = 4'($urandom);
    op_addr = $urandom;
    check("ready_fall", 64'(op_ready), 64'(0));
    check("busy_rise", 64'(busy), 64'(1));
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'(1));
    act_n = log_q.size();
    act_err = done_err;
    act_sr = done_sr;
    check("txn_count", 64'(log_q.size()), 64'(exp_q.size()));
    nmin = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check("txn_fields", 64'(norm(log_q[i])), 64'(norm(exp_q[i])));
    check("op_error", 64'(done_err), 64'(m_err));
    check("sr_out", 64'(done_sr), 64'(m_sr));
    check("fields_stable", 64'(unstable), 64'(0));
    if (exp_q.size() == 0) check("illegal_latency", 64'(done_cyc - acc), 64'(2));
    else if (dcyc_q.size() > 0) check("done_latency", 64'(done_cyc - dcyc_q[dcyc_q.size()-1]),
                                      64'(1));
    for (int i = 1; i < log_q.size() && i < vcyc_q.size(); i++) begin
      if (log_q[i].opcode == 8'h05 && log_q[i-1].opcode == 8'h05)
        check("poll_gap", 64'(vcyc_q[i] > dcyc_q[i-1] + PollGap), 64'(1));
    end
    @(negedge clk); #1;
    check("ready_rise", 64'(op_ready), 64'(1));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish (%0d checks so far)", n_checks);
    $fatal(1);
  end

  initial begin
    int         an;
    logic       aerr;
    logic [7:0] asr;
    int         t;
    int         d0;
    logic [3:0] code;
    logic [7:0] b;

    vecs[0] = '{4'hE, 32'h0000_0000,  0, 8'h02,  0, 1, 1'b0, 8'h02};
    vecs[1] = '{4'hC, 32'h0001_2300,  2, 8'h00,  1, 5, 1'b0, 8'h00};
    vecs[2] = '{4'hA, 32'h01FF_1000, 10, 8'h00,  0, 6, 1'b1, 8'h01};
    vecs[3] = '{4'hD, 32'h00AB_CDEF,  0, 8'h00, 10, 1, 1'b0, 8'h01};
    vecs[4] = '{4'h3, 32'h1234_5678,  0, 8'h00,  0, 0, 1'b1, 8'h01};
    vecs[5] = '{4'hE, 32'hFFFF_FFFF,  0, 8'h40,  2, 1, 1'b0, 8'h40};

    repeat (3) @(negedge clk);
    #1;
    check("rst_op_ready", 64'(op_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_op_done", 64'(op_done), 64'(0));
    check("rst_op_error", 64'(op_error), 64'(0));
    check("rst_sr_out", 64'(sr_out), 64'(0));
    check("rst_eng_valid", 64'(eng_valid), 64'(0));
    check("rst_eng_fields", 64'({eng_opcode, eng_addr, eng_addr_en, eng_len}), 64'(0));
    rst = 1'b0;
    @(negedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      resp_q.delete();
      for (int j = 0; j < vecs[v].n_wip; j++) resp_q.push_back(8'h01);
      resp_q.push_back(vecs[v].fin);
      run_op(vecs[v].code, vecs[v].addr, vecs[v].rdly, an, aerr, asr);
      check("vec_txn_count", 64'(an), 64'(vecs[v].exp_n));
      check("vec_error", 64'(aerr), 64'(vecs[v].exp_err));
      check("vec_sr", 64'(asr), 64'(vecs[v].exp_sr));
      if (vecs[v].code == 4'hA) check("erase_eng_addr", 64'(eng_addr), 64'(24'hFF1000));
    end

    // Reset while a program op sits in GAP.
    resp_q.delete();
    for (int j = 0; j < 10; j++) resp_q.push_back(8'h01);
    log_q.delete();
    vcyc_q.delete();
    dcyc_q.delete();
    ready_dly = 0;
    op_valid = 1'b1;
    op_code = 4'hC;
    op_addr = 32'h0000_4400;
    @(negedge clk); #1;
    op_valid = 1'b0;
    t = 0;
    while (dcyc_q.size() < 2 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    check("reached_gap", 64'(dcyc_q.size()), 64'(2));
    repeat (3) @(negedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_op_ready", 64'(op_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_eng_valid", 64'(eng_valid), 64'(0));
    check("midrst_sr_out", 64'(sr_out), 64'(0));
    rst = 1'b0;
    repeat (2 * PollGap) @(negedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'(0));
    check("midrst_no_txn", 64'(log_q.size()), 64'(2));
    m_sr = 8'h00;
    resp_q.delete();
    resp_q.push_back(8'h00);
    run_op(4'hA, 32'h0034_5000, 0, an, aerr, asr);
    check("post_rst_erase_txns", 64'(an), 64'(3));

    // Randomized operations against the model.
    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 4))
        0: code = 4'hA;
        1: code = 4'hC;
        2: code = 4'hD;
        3: code = 4'hE;
        default: code = 4'($urandom_range(0, 9));
      endcase
      resp_q.delete();
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) begin
        b = 8'($urandom);
        b[0] = 1'b1;
        resp_q.push_back(b);
      end
      b = 8'($urandom);
      b[0] = 1'b0;
      resp_q.push_back(b);
      run_op(code, $urandom, int'($urandom_range(0, 3)), an, aerr, asr);
    end

    check("no_stray_error", 64'(stray), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
